// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic_array tile-job sequencer.
// Holds the sequencer state encoding, counter widths and the PE lane-mask helper.
package systolic_pkg;

    localparam int CNT_W    = 10;
    localparam int PE_IDX_W = 6;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_START  = 3'd2,
        S_STREAM = 3'd3,
        S_WAIT   = 3'd4,
        S_SETTLE = 3'd5,
        S_DRAIN  = 3'd6,
        S_CLEAR  = 3'd7
    } seq_state_t;

    // Lane 'lane' belongs to the active PE set when its index is below N.
    function automatic logic lane_active(input logic [PE_IDX_W-1:0] n, input int unsigned lane);
        return (lane < 32'(n));
    endfunction

endpackage

// File: rtl/seq_row_feeder.sv
// Moves operand rows from the operand buffer into the array weight/input FIFOs.
// Keeps at most one buffer read in flight and writes each returned row to the active lanes only.
module seq_row_feeder
    import systolic_pkg::*;
#(
    parameter int ARRAY_SIZE = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 job_start,
    input  logic                                 feed_en,
    input  logic [CNT_W-1:0]                     limit,
    input  logic [PE_IDX_W-1:0]                  n,
    input  logic [ARRAY_SIZE-1:0]                full_w,
    input  logic [ARRAY_SIZE-1:0]                full_i,
    input  logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] buf_w,
    input  logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] buf_i,
    output logic                                 buf_rd_en,
    output logic [CNT_W-1:0]                     buf_rd_addr,
    output logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] sa_weights,
    output logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] sa_inputs,
    output logic [ARRAY_SIZE-1:0]                sa_wren_w,
    output logic [ARRAY_SIZE-1:0]                sa_wren_i,
    output logic                                 wr_now,
    output logic [CNT_W-1:0]                     rd_written
);

    logic [CNT_W-1:0]      rd_issued_q, rd_issued_d;
    logic [CNT_W-1:0]      rd_written_q, rd_written_d;
    logic                  in_flight_q, in_flight_d;
    logic [ARRAY_SIZE-1:0] mask_s;
    logic                  lane_blocked_s;
    logic                  rd_en_s;

    // Active-lane mask derived from the latched PE count.
    always_comb begin
        for (int i = 0; i < ARRAY_SIZE; i++) begin
            mask_s[i] = lane_active(n, i);
        end
    end

    // Full flags on inactive lanes must not stall the job.
    assign lane_blocked_s = |((full_w | full_i) & mask_s);
    assign rd_en_s = feed_en && (rd_issued_q < limit) && !in_flight_q && !lane_blocked_s;

    // Issue/write counters and the single in-flight read flag.
    always_comb begin
        rd_issued_d  = rd_issued_q;
        rd_written_d = rd_written_q;
        in_flight_d  = 1'b0;
        if (job_start) begin
            rd_issued_d  = {CNT_W{1'b0}};
            rd_written_d = {CNT_W{1'b0}};
        end else begin
            if (rd_en_s) begin
                rd_issued_d = rd_issued_q + CNT_W'(1);
                in_flight_d = 1'b1;
            end else begin
                in_flight_d = 1'b0;
            end
            if (in_flight_q) begin
                rd_written_d = rd_written_q + CNT_W'(1);
            end else begin
                rd_written_d = rd_written_q;
            end
        end
    end

    // Counter and in-flight registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_issued_q  <= {CNT_W{1'b0}};
            rd_written_q <= {CNT_W{1'b0}};
            in_flight_q  <= 1'b0;
        end else begin
            rd_issued_q  <= rd_issued_d;
            rd_written_q <= rd_written_d;
            in_flight_q  <= in_flight_d;
        end
    end

    // Buffer data arrives the cycle after the read, which is exactly the write cycle.
    assign buf_rd_en   = rd_en_s;
    assign buf_rd_addr = rd_issued_q;
    assign sa_wren_w   = in_flight_q ? mask_s : {ARRAY_SIZE{1'b0}};
    assign sa_wren_i   = in_flight_q ? mask_s : {ARRAY_SIZE{1'b0}};
    assign sa_weights  = in_flight_q ? buf_w : '0;
    assign sa_inputs   = in_flight_q ? buf_i : '0;
    assign wr_now      = in_flight_q;
    assign rd_written  = rd_written_q;

endmodule

// File: rtl/systolic_seq.sv
// Tile-job sequencer for one systolic_array: loads K operand rows, starts the array,
// waits for completion, drains N result rows to the consumer and clears the array.
module systolic_seq
    import systolic_pkg::*;
#(
    parameter int ARRAY_SIZE = 16,
    parameter int DATA_WIDTH = 8,
    parameter int PRELOAD    = 4,
    parameter int PE_LAT     = 2
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic                                                cmd_valid,
    output logic                                                cmd_ready,
    input  logic [CNT_W-1:0]                                    cmd_k,
    input  logic [PE_IDX_W-1:0]                                 cmd_n,
    output logic                                                buf_rd_en,
    output logic [CNT_W-1:0]                                    buf_rd_addr,
    input  logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0]               buf_w,
    input  logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0]               buf_i,
    output logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0]               sa_weights,
    output logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0]               sa_inputs,
    output logic [ARRAY_SIZE-1:0]                               sa_wren_w,
    output logic [ARRAY_SIZE-1:0]                               sa_wren_i,
    input  logic [ARRAY_SIZE-1:0]                               sa_full_w,
    input  logic [ARRAY_SIZE-1:0]                               sa_full_i,
    output logic                                                sa_start,
    output logic                                                sa_clr,
    output logic [PE_IDX_W-1:0]                                 sa_activated_pe,
    input  logic [CNT_W-1:0]                                    sa_cnt,
    input  logic [ARRAY_SIZE-1:0][ARRAY_SIZE-1:0][4*DATA_WIDTH-1:0] sa_O,
    output logic                                                res_valid,
    input  logic                                                res_ready,
    output logic [PE_IDX_W-1:0]                                 res_row,
    output logic [ARRAY_SIZE-1:0][4*DATA_WIDTH-1:0]             res_data,
    output logic                                                busy,
    output logic                                                done,
    output logic                                                err
);

    localparam int RES_W = 4 * DATA_WIDTH;
    localparam int ROW_W = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
    localparam int SET_W = 8;

    seq_state_t                        state_q, state_d;
    logic [CNT_W-1:0]                  k_q, k_d;
    logic [PE_IDX_W-1:0]               n_q, n_d;
    logic [SET_W-1:0]                  settle_q, settle_d;
    logic                              cmd_ready_q, cmd_ready_d;
    logic                              busy_q, busy_d;
    logic                              done_q, done_d;
    logic                              err_q, err_d;
    logic                              start_q, start_d;
    logic                              clr_q, clr_d;
    logic                              res_valid_q, res_valid_d;
    logic [PE_IDX_W-1:0]               res_row_q, res_row_d;
    logic [ARRAY_SIZE-1:0][RES_W-1:0]  res_data_q, res_data_d;

    logic                              job_start_s;
    logic                              feed_en_s;
    logic [CNT_W-1:0]                  feed_limit_s;
    logic [CNT_W-1:0]                  preload_tgt_s;
    logic                              wr_now_s;
    logic [CNT_W-1:0]                  rd_written_s;
    logic                              cmd_bad_s;

    assign preload_tgt_s = (k_q < CNT_W'(PRELOAD)) ? k_q : CNT_W'(PRELOAD);
    assign feed_en_s     = (state_q == S_LOAD) || (state_q == S_STREAM);
    assign feed_limit_s  = (state_q == S_LOAD) ? preload_tgt_s : k_q;
    assign cmd_bad_s     = (cmd_k == {CNT_W{1'b0}}) || (cmd_n < PE_IDX_W'(2)) ||
                           (cmd_n > PE_IDX_W'(ARRAY_SIZE));

    seq_row_feeder #(
        .ARRAY_SIZE (ARRAY_SIZE),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_feeder (
        .clk         (clk),
        .rst         (rst),
        .job_start   (job_start_s),
        .feed_en     (feed_en_s),
        .limit       (feed_limit_s),
        .n           (n_q),
        .full_w      (sa_full_w),
        .full_i      (sa_full_i),
        .buf_w       (buf_w),
        .buf_i       (buf_i),
        .buf_rd_en   (buf_rd_en),
        .buf_rd_addr (buf_rd_addr),
        .sa_weights  (sa_weights),
        .sa_inputs   (sa_inputs),
        .sa_wren_w   (sa_wren_w),
        .sa_wren_i   (sa_wren_i),
        .wr_now      (wr_now_s),
        .rd_written  (rd_written_s)
    );

    // Job sequencing: next state and next values of every registered output.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        n_d         = n_q;
        settle_d    = settle_q;
        cmd_ready_d = cmd_ready_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        start_d     = 1'b0;
        clr_d       = 1'b0;
        res_valid_d = res_valid_q;
        res_row_d   = res_row_q;
        res_data_d  = res_data_q;
        job_start_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    k_d         = cmd_k;
                    n_d         = cmd_n;
                    job_start_s = 1'b1;
                    if (cmd_bad_s) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        state_d     = S_LOAD;
                        cmd_ready_d = 1'b0;
                        busy_d      = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (wr_now_s && ((rd_written_s + CNT_W'(1)) == preload_tgt_s)) begin
                    state_d = S_START;
                    start_d = 1'b1;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_START: begin
                if (rd_written_s < k_q) begin
                    state_d = S_STREAM;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_STREAM: begin
                if (wr_now_s && ((rd_written_s + CNT_W'(1)) == k_q)) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_STREAM;
                end
            end
            S_WAIT: begin
                if (sa_cnt >= k_q) begin
                    state_d  = S_SETTLE;
                    settle_d = {SET_W{1'b0}};
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_SETTLE: begin
                if (settle_q == SET_W'(PE_LAT - 1)) begin
                    state_d     = S_DRAIN;
                    res_valid_d = 1'b1;
                    res_row_d   = {PE_IDX_W{1'b0}};
                    res_data_d  = sa_O[{ROW_W{1'b0}}];
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            S_DRAIN: begin
                // Row data is captured on advance so it stays stable under backpressure.
                if (res_ready) begin
                    if (res_row_q == (n_q - PE_IDX_W'(1))) begin
                        state_d     = S_CLEAR;
                        res_valid_d = 1'b0;
                        clr_d       = 1'b1;
                        done_d      = 1'b1;
                        busy_d      = 1'b0;
                    end else begin
                        res_row_d  = res_row_q + PE_IDX_W'(1);
                        res_data_d = sa_O[ROW_W'(res_row_q + PE_IDX_W'(1))];
                    end
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_CLEAR: begin
                state_d     = S_IDLE;
                cmd_ready_d = 1'b1;
            end
            default: begin
                state_d     = S_IDLE;
                cmd_ready_d = 1'b1;
                busy_d      = 1'b0;
                res_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            k_q         <= {CNT_W{1'b0}};
            n_q         <= {PE_IDX_W{1'b0}};
            settle_q    <= {SET_W{1'b0}};
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            start_q     <= 1'b0;
            clr_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_row_q   <= {PE_IDX_W{1'b0}};
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            n_q         <= n_d;
            settle_q    <= settle_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            start_q     <= start_d;
            clr_q       <= clr_d;
            res_valid_q <= res_valid_d;
            res_row_q   <= res_row_d;
            res_data_q  <= res_data_d;
        end
    end

    assign cmd_ready       = cmd_ready_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign err             = err_q;
    assign sa_start        = start_q;
    assign sa_clr          = clr_q;
    assign sa_activated_pe = n_q;
    assign res_valid       = res_valid_q;
    assign res_row         = res_row_q;
    assign res_data        = res_data_q;

endmodule

// File: tb/tb_systolic_seq.sv
// Self-checking bench for systolic_seq: operand-row scoreboard filled on buffer reads and
// drained on FIFO writes, plus a result-row queue checked during the drain handshake.
module tb_systolic_seq;

    localparam int AS  = 16;
    localparam int DW  = 8;
    localparam int RW  = 4 * DW;
    localparam int PRE = 4;
    localparam int PL  = 2;

    logic                           clk = 1'b0;
    logic                           rst, cmd_valid, cmd_ready;
    logic [9:0]                     cmd_k;
    logic [5:0]                     cmd_n;
    logic                           buf_rd_en;
    logic [9:0]                     buf_rd_addr;
    logic [AS-1:0][DW-1:0]          buf_w, buf_i, sa_weights, sa_inputs;
    logic [AS-1:0]                  sa_wren_w, sa_wren_i, sa_full_w, sa_full_i;
    logic                           sa_start, sa_clr;
    logic [5:0]                     sa_activated_pe;
    logic [9:0]                     sa_cnt;
    logic [AS-1:0][AS-1:0][RW-1:0]  sa_O;
    logic                           res_valid, res_ready;
    logic [5:0]                     res_row;
    logic [AS-1:0][RW-1:0]          res_data;
    logic                           busy, done, err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rd_cnt, wr_cnt, start_cnt, clr_cnt, done_cnt, err_cnt;
    int exp_addr, pre_tgt, pre_cyc, start_cyc;
    logic [AS-1:0]         exp_mask;
    logic [AS-1:0][DW-1:0] exp_w_q[$];
    logic [AS-1:0][DW-1:0] exp_i_q[$];
    logic [AS-1:0][RW-1:0] exp_res_q[$];

    systolic_seq #(.ARRAY_SIZE(AS), .DATA_WIDTH(DW), .PRELOAD(PRE), .PE_LAT(PL)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_k(cmd_k), .cmd_n(cmd_n), .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr),
        .buf_w(buf_w), .buf_i(buf_i), .sa_weights(sa_weights), .sa_inputs(sa_inputs),
        .sa_wren_w(sa_wren_w), .sa_wren_i(sa_wren_i), .sa_full_w(sa_full_w), .sa_full_i(sa_full_i),
        .sa_start(sa_start), .sa_clr(sa_clr), .sa_activated_pe(sa_activated_pe), .sa_cnt(sa_cnt),
        .sa_O(sa_O), .res_valid(res_valid), .res_ready(res_ready), .res_row(res_row),
        .res_data(res_data), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [AS-1:0][DW-1:0] mk_row(input int a, input int sel);
        logic [AS-1:0][DW-1:0] r;
        for (int j = 0; j < AS; j++) r[j] = DW'(a * 37 + j * 11 + sel * 89 + 3);
        return r;
    endfunction

    // One clock: model the operand buffer, score FIFO writes, count control pulses.
    task automatic step();
        logic rd;
        logic [9:0] a;
        logic [AS-1:0][DW-1:0] ew, ei;
        #1;
        rd = buf_rd_en;
        a  = buf_rd_addr;
        if (rd) begin
            checks++;
            if (a !== 10'(exp_addr)) begin
                errors++;
                $display("FAIL rd_addr: got %0d expected %0d", a, exp_addr);
            end
            exp_w_q.push_back(mk_row(exp_addr, 0));
            exp_i_q.push_back(mk_row(exp_addr, 1));
            exp_addr++;
            rd_cnt++;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rd) begin
            buf_w = mk_row(int'(a), 0);
            buf_i = mk_row(int'(a), 1);
        end else begin
            for (int j = 0; j < AS; j++) begin
                buf_w[j] = DW'($urandom);
                buf_i[j] = DW'($urandom);
            end
        end
        #1;
        if (sa_wren_w !== '0 || sa_wren_i !== '0) begin
            wr_cnt++;
            if (wr_cnt == pre_tgt) pre_cyc = cyc;
            checks++;
            if (exp_w_q.size() == 0) begin
                errors++;
                $display("FAIL fifo_write: unexpected write mask_w=%h mask_i=%h", sa_wren_w, sa_wren_i);
            end else begin
                ew = exp_w_q.pop_front();
                ei = exp_i_q.pop_front();
                if (sa_wren_w !== exp_mask || sa_wren_i !== exp_mask || sa_weights !== ew || sa_inputs !== ei) begin
                    errors++;
                    $display("FAIL fifo_write: masks %h/%h data %h/%h expected mask %h data %h/%h",
                             sa_wren_w, sa_wren_i, sa_weights, sa_inputs, exp_mask, ew, ei);
                end
            end
        end
        if (sa_start === 1'b1) begin
            start_cnt++;
            start_cyc = cyc;
        end
        if (sa_clr === 1'b1) clr_cnt++;
        if (done === 1'b1) done_cnt++;
        if (err === 1'b1) err_cnt++;
    endtask

    task automatic set_sa_o(input int seed);
        for (int r = 0; r < AS; r++)
            for (int c = 0; c < AS; c++)
                sa_O[r][c] = RW'(seed * 65536 + r * 256 + c);
    endtask

    // Accept one command; for legal commands also check first read at T+1 and first write at T+2.
    task automatic send_cmd(input int k, input int n);
        bit ok;
        ok = (k != 0) && (n >= 2) && (n <= AS);
        rd_cnt = 0; wr_cnt = 0; start_cnt = 0; clr_cnt = 0; done_cnt = 0; err_cnt = 0;
        exp_addr = 0; pre_cyc = -1; start_cyc = -1;
        pre_tgt = (k < PRE) ? k : PRE;
        exp_w_q.delete(); exp_i_q.delete();
        for (int i = 0; i < AS; i++) exp_mask[i] = (i < n);
        sa_cnt = '0;
        cmd_valid = 1'b1; cmd_k = 10'(k); cmd_n = 6'(n);
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL cmd_ready_idle: got %b expected 1", cmd_ready);
        end
        step();
        cmd_valid = 1'b0;
        checks++;
        if (sa_activated_pe !== 6'(n)) begin
            errors++;
            $display("FAIL activated_pe: got %0d expected %0d", sa_activated_pe, n);
        end
        if (ok) begin
            checks++;
            if (buf_rd_en !== 1'b1 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL first_read: rd_en=%b busy=%b cmd_ready=%b expected 1,1,0", buf_rd_en, busy, cmd_ready);
            end
            step();
            checks++;
            if (sa_wren_w !== exp_mask) begin
                errors++;
                $display("FAIL first_write: mask %h expected %h", sa_wren_w, exp_mask);
            end
        end
    endtask

    // Run the fill until all K rows are written; optionally apply an 8-cycle full window in STREAM.
    task automatic feed(input int k, input bit bp);
        int guard = 0;
        bit bp_done = 1'b0;
        int r0, w0;
        while ((wr_cnt < k || start_cnt == 0) && guard < 400) begin
            if (bp && !bp_done && start_cnt == 1 && cyc == start_cyc + 2) begin
                bp_done = 1'b1;
                sa_full_i[2] = 1'b1;
                r0 = rd_cnt; w0 = wr_cnt;
                repeat (8) step();
                sa_full_i[2] = 1'b0;
                checks++;
                if (rd_cnt != r0 || wr_cnt > w0 + 1) begin
                    errors++;
                    $display("FAIL backpressure: reads %0d->%0d writes %0d->%0d", r0, rd_cnt, w0, wr_cnt);
                end
            end
            step();
            guard++;
        end
        checks++;
        if (guard >= 400) begin
            errors++;
            $display("FAIL feed_timeout: writes %0d expected %0d", wr_cnt, k);
        end
        checks++;
        if (start_cnt != 1 || start_cyc != pre_cyc + 1) begin
            errors++;
            $display("FAIL start_pulse: count %0d at cycle %0d expected 1 at %0d", start_cnt, start_cyc, pre_cyc + 1);
        end
        repeat (4) step();
        checks++;
        if (rd_cnt != k || wr_cnt != k || exp_w_q.size() != 0 || res_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL row_count: reads %0d writes %0d pending %0d res_valid %b busy %b expected %0d,%0d,0,0,1",
                     rd_cnt, wr_cnt, exp_w_q.size(), res_valid, busy, k, k);
        end
    endtask

    // Complete the job: gate on sa_cnt, check settle latency, drain rows, then clear/done.
    task automatic drain(input int k, input int n, input int stall_row, input int stall_len);
        int lat = 0;
        int accepted = 0;
        int stall_left;
        int guard = 0;
        stall_left = stall_len;
        sa_cnt = 10'(k - 1);
        repeat (3) step();
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("FAIL wait_gate: res_valid %b with sa_cnt=K-1 expected 0", res_valid);
        end
        sa_cnt = 10'(k);
        while (res_valid !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        checks++;
        if (lat != 1 + PL) begin
            errors++;
            $display("FAIL settle_latency: got %0d cycles expected %0d", lat, 1 + PL);
        end
        exp_res_q.delete();
        for (int r = 0; r < n; r++) exp_res_q.push_back(sa_O[r]);
        while (accepted < n && guard < 200) begin
            guard++;
            checks++;
            if (res_valid !== 1'b1 || res_row !== 6'(accepted) || res_data !== exp_res_q[0]) begin
                errors++;
                $display("FAIL res_row: valid %b row %0d data %h expected 1 row %0d data %h",
                         res_valid, res_row, res_data, accepted, exp_res_q[0]);
            end
            if (accepted == stall_row && stall_left > 0) begin
                res_ready = 1'b0;
                stall_left--;
            end else begin
                res_ready = 1'b1;
            end
            step();
            if (res_ready) begin
                accepted++;
                void'(exp_res_q.pop_front());
            end
        end
        res_ready = 1'b1;
        checks++;
        if (sa_clr !== 1'b1 || done !== 1'b1 || err !== 1'b0 || busy !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL clear: clr %b done %b err %b busy %b res_valid %b expected 1,1,0,0,0",
                     sa_clr, done, err, busy, res_valid);
        end
        step();
        checks++;
        if (cmd_ready !== 1'b1 || sa_clr !== 1'b0 || clr_cnt != 1 || done_cnt != 1 || err_cnt != 0) begin
            errors++;
            $display("FAIL job_end: cmd_ready %b clr %b clr_cnt %0d done_cnt %0d err_cnt %0d expected 1,0,1,1,0",
                     cmd_ready, sa_clr, clr_cnt, done_cnt, err_cnt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: ready %b busy %b done %b err %b expected 1,0,0,0", cmd_ready, busy, done, err);
        end
        checks++;
        if (sa_start !== 1'b0 || sa_clr !== 1'b0 || buf_rd_en !== 1'b0 || sa_wren_w !== '0 || sa_wren_i !== '0) begin
            errors++;
            $display("FAIL reset_array: start %b clr %b rd %b wren %h/%h expected all 0",
                     sa_start, sa_clr, buf_rd_en, sa_wren_w, sa_wren_i);
        end
        checks++;
        if (res_valid !== 1'b0 || res_row !== 6'd0 || sa_activated_pe !== 6'd0 || res_data !== '0) begin
            errors++;
            $display("FAIL reset_result: valid %b row %0d pe %0d expected 0,0,0", res_valid, res_row, sa_activated_pe);
        end
    endtask

    task automatic test_small();
        set_sa_o(1);
        send_cmd(3, 4);
        feed(3, 1'b0);
        drain(3, 4, -1, 0);
    endtask

    task automatic test_k10();
        set_sa_o(2);
        send_cmd(10, 16);
        feed(10, 1'b0);
        drain(10, 16, -1, 0);
    endtask

    task automatic test_backpressure();
        set_sa_o(3);
        sa_full_w[8] = 1'b1;
        send_cmd(12, 4);
        feed(12, 1'b1);
        drain(12, 4, 1, 5);
        sa_full_w = '0;
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        int r0;
        set_sa_o(4);
        send_cmd(20, 4);
        while (start_cnt == 0 && guard < 100) begin
            step();
            guard++;
        end
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_w_q.delete(); exp_i_q.delete();
        r0 = rd_cnt;
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || buf_rd_en !== 1'b0 ||
            sa_wren_w !== '0 || sa_weights !== '0 || sa_activated_pe !== 6'd0 || sa_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: ready %b busy %b done %b rd %b wren %h pe %0d start %b expected 1,0,0,0,0,0,0",
                     cmd_ready, busy, done, buf_rd_en, sa_wren_w, sa_activated_pe, sa_start);
        end
        repeat (6) step();
        checks++;
        if (rd_cnt != r0 || done_cnt != 0 || clr_cnt != 0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_quiet: reads %0d->%0d done_cnt %0d clr_cnt %0d ready %b",
                     r0, rd_cnt, done_cnt, clr_cnt, cmd_ready);
        end
    endtask

    task automatic test_errors();
        int ks[3] = '{5, 0, 4};
        int ns[3] = '{1, 4, 17};
        for (int t = 0; t < 3; t++) begin
            send_cmd(ks[t], ns[t]);
            checks++;
            if (done !== 1'b1 || err !== 1'b1 || cmd_ready !== 1'b1 || buf_rd_en !== 1'b0) begin
                errors++;
                $display("FAIL err_pulse k=%0d n=%0d: done %b err %b ready %b rd %b expected 1,1,1,0",
                         ks[t], ns[t], done, err, cmd_ready, buf_rd_en);
            end
            repeat (4) step();
            checks++;
            if (rd_cnt != 0 || start_cnt != 0 || clr_cnt != 0 || done_cnt != 1 || err_cnt != 1 || wr_cnt != 0) begin
                errors++;
                $display("FAIL err_quiet k=%0d n=%0d: rd %0d start %0d clr %0d done %0d err %0d wr %0d",
                         ks[t], ns[t], rd_cnt, start_cnt, clr_cnt, done_cnt, err_cnt, wr_cnt);
            end
        end
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_k = '0; cmd_n = '0;
        buf_w = '0; buf_i = '0; sa_full_w = '0; sa_full_i = '0;
        sa_cnt = '0; sa_O = '0; res_ready = 1'b1;
        rd_cnt = 0; wr_cnt = 0; start_cnt = 0; clr_cnt = 0; done_cnt = 0; err_cnt = 0;
        exp_addr = 0; pre_tgt = 0; pre_cyc = -1; start_cyc = -1; exp_mask = '0;
        test_reset();
        test_small();
        test_k10();
        test_backpressure();
        test_reset_mid();
        test_errors();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
